// File: rtl/fault_pkg.sv
// Shared definitions for the phase-C fault path: data width, default window
// length, acquisition state encoding and the saturated magnitude limit that
// the downstream fault_classifier thresholds are scaled against.
package fault_pkg;

   localparam int DATA_W     = 16;
   localparam int WINDOW_LEN = 64;

   // Largest positive DATA_W-bit value; also the result of |most-negative|.
   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

   typedef enum logic {
      IDLE = 1'b0,
      ACQ  = 1'b1
   } pk_state_e;

endpackage : fault_pkg

// File: rtl/phase_peak_detector_sat_abs.sv
// Combinational saturated absolute value of a signed two's complement word.
// The most-negative input has no positive counterpart, so it clamps to the
// largest positive value instead of wrapping back to itself.
module sat_abs #(
   parameter int DATA_W = fault_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] i_x,
   output logic [DATA_W-1:0] o_abs
);

   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

   // Magnitude: pass positives, negate negatives, clamp the most-negative code.
   always_comb begin
      o_abs = i_x;
      if (i_x == MOST_NEG) begin
         o_abs = MOST_POS;
      end else if (i_x[DATA_W-1]) begin
         o_abs = (~i_x) + {{(DATA_W-1){1'b0}}, 1'b1};
      end else begin
         o_abs = i_x;
      end
   end

endmodule : sat_abs

// File: rtl/phase_peak_detector.sv
// Phase-C peak extractor: tracks the saturated |V| and |I| maxima over one
// mains-cycle window and publishes them with a one-cycle peak_valid strobe.
// A sync pulse realigns the window to the zero crossing; en=0 parks the block
// in IDLE and drops any partial window while the published peaks hold.
module phase_peak_detector
   import fault_pkg::*;
#(
   parameter int DATA_W     = fault_pkg::DATA_W,
   parameter int WINDOW_LEN = fault_pkg::WINDOW_LEN,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     sync,
   input  logic                     sample_valid,
   input  logic signed [DATA_W-1:0] Vc_sample,
   input  logic signed [DATA_W-1:0] Ic_sample,
   output logic signed [DATA_W-1:0] Vc_peak,
   output logic signed [DATA_W-1:0] Ic_peak,
   output logic                     peak_valid,
   output logic                     busy
);

   // Count value held before the sample that completes the window.
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_LEN - 1);

   pk_state_e          r_state;
   pk_state_e          w_state_nxt;
   logic [CNT_W-1:0]   r_count;
   logic [DATA_W-1:0]  r_vmax;
   logic [DATA_W-1:0]  r_imax;
   logic [DATA_W-1:0]  r_vpeak;
   logic [DATA_W-1:0]  r_ipeak;
   logic               r_peak_valid;
   logic [DATA_W-1:0]  w_vabs;
   logic [DATA_W-1:0]  w_iabs;
   logic [DATA_W-1:0]  w_vmax_nxt;
   logic [DATA_W-1:0]  w_imax_nxt;
   logic               w_last;

   sat_abs #(.DATA_W(DATA_W)) u_vabs (
      .i_x   (Vc_sample),
      .o_abs (w_vabs)
   );

   sat_abs #(.DATA_W(DATA_W)) u_iabs (
      .i_x   (Ic_sample),
      .o_abs (w_iabs)
   );

   // Running maxima including the current sample; unsigned compare is exact
   // because both operands are non-negative magnitudes.
   always_comb begin
      w_vmax_nxt = r_vmax;
      w_imax_nxt = r_imax;
      if (w_vabs > r_vmax) begin
         w_vmax_nxt = w_vabs;
      end else begin
         w_vmax_nxt = r_vmax;
      end
      if (w_iabs > r_imax) begin
         w_imax_nxt = w_iabs;
      end else begin
         w_imax_nxt = r_imax;
      end
      w_last = (r_count == LAST_IDX);
   end

   // Next-state logic: en alone decides between IDLE and ACQ.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (en) begin
               w_state_nxt = ACQ;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ACQ: begin
            if (!en) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = ACQ;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Window accumulation, sync realignment and peak publication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count      <= '0;
         r_vmax       <= '0;
         r_imax       <= '0;
         r_vpeak      <= '0;
         r_ipeak      <= '0;
         r_peak_valid <= 1'b0;
      end else begin
         r_peak_valid <= 1'b0;
         if ((r_state != ACQ) || !en) begin
            // Not acquiring (or leaving ACQ): partial window is discarded.
            r_count <= '0;
            r_vmax  <= '0;
            r_imax  <= '0;
         end else if (sync) begin
            // Zero crossing wins over completion; a coincident sample opens
            // the new window as its first sample.
            if (sample_valid) begin
               r_count <= CNT_W'(1);
               r_vmax  <= w_vabs;
               r_imax  <= w_iabs;
            end else begin
               r_count <= '0;
               r_vmax  <= '0;
               r_imax  <= '0;
            end
         end else if (sample_valid) begin
            if (w_last) begin
               r_vpeak      <= w_vmax_nxt;
               r_ipeak      <= w_imax_nxt;
               r_peak_valid <= 1'b1;
               r_count      <= '0;
               r_vmax       <= '0;
               r_imax       <= '0;
            end else begin
               r_count <= r_count + CNT_W'(1);
               r_vmax  <= w_vmax_nxt;
               r_imax  <= w_imax_nxt;
            end
         end
      end
   end

   assign Vc_peak    = r_vpeak;
   assign Ic_peak    = r_ipeak;
   assign peak_valid = r_peak_valid;
   assign busy       = (r_state == ACQ);

endmodule : phase_peak_detector

// File: tb/tb_phase_peak_detector.sv
// Scoreboard bench for phase_peak_detector with a 4-sample window.
// Expected peaks are queued before the completing sample is driven and are
// popped by a monitor on every peak_valid strobe.
module tb_phase_peak_detector;

   localparam int DW = 16;
   localparam int WL = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 en = 1'b0;
   logic                 sync = 1'b0;
   logic                 sample_valid = 1'b0;
   logic signed [DW-1:0] Vc_sample = '0;
   logic signed [DW-1:0] Ic_sample = '0;
   logic signed [DW-1:0] Vc_peak;
   logic signed [DW-1:0] Ic_peak;
   logic                 peak_valid;
   logic                 busy;

   typedef struct {
      int v;
      int i;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   phase_peak_detector #(.DATA_W(DW), .WINDOW_LEN(WL), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sync         (sync),
      .sample_valid (sample_valid),
      .Vc_sample    (Vc_sample),
      .Ic_sample    (Ic_sample),
      .Vc_peak      (Vc_peak),
      .Ic_peak      (Ic_peak),
      .peak_valid   (peak_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest queued window.
   always @(negedge clk) begin
      if (!rst && peak_valid) begin
         if (sb_q.size() == 0) begin
            check_val("spurious_peak_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("Vc_peak", int'(Vc_peak), e.v);
            check_val("Ic_peak", int'(Ic_peak), e.i);
         end
      end
   end

   // Drive one sample (optionally with sync), then idle for gap cycles.
   // Entry/exit timing: 1 time unit after a rising edge.
   task automatic smp(input int v, input int i, input int gap, input logic s = 1'b0);
      sample_valid = 1'b1;
      sync         = s;
      Vc_sample    = DW'(v);
      Ic_sample    = DW'(i);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      sync         = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic push_exp(input int v, input int i);
      exp_t e;
      e.v = v;
      e.i = i;
      sb_q.push_back(e);
   endtask

   // Bounded wait for all queued windows to be published.
   task automatic drain(input string tag);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check_val(tag, sb_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_Vc_peak", int'(Vc_peak), 0);
      check_val("rst_Ic_peak", int'(Ic_peak), 0);
      check_val("rst_peak_valid", int'(peak_valid), 0);
      check_val("rst_busy", int'(busy), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_val("idle_busy", int'(busy), 0);
      en = 1'b1;
      @(posedge clk); #1;
      check_val("acq_busy", int'(busy), 1);

      // Basic contiguous window.
      smp(100, -10000, 0);
      smp(-3000, 200, 0);
      smp(2500, 9000, 0);
      push_exp(3000, 10000);
      smp(7, -1, 0);
      drain("t1_drain");
      repeat (3) @(posedge clk);
      #1;
      check_val("t1_hold_Vc", int'(Vc_peak), 3000);
      check_val("t1_hold_pv", int'(peak_valid), 0);

      // Saturation of the most-negative code.
      smp(-32768, 1, 0);
      smp(5, 2, 0);
      smp(-6, 3, 0);
      push_exp(32767, 4);
      smp(100, -4, 0);
      drain("t2_drain");

      // Gaps then back-to-back window with no carry-over.
      smp(100, -10000, 0);
      smp(-3000, 200, 3);
      smp(2500, 9000, 7);
      push_exp(3000, 10000);
      smp(7, -1, 0);
      smp(4500, -20000, 0);
      smp(4500, -20000, 0);
      smp(4500, -20000, 0);
      push_exp(4500, 20000);
      smp(4500, -20000, 0);
      drain("t3_drain");

      // Sync with a sample restarts the window at sample 1.
      smp(6000, -6000, 0);
      smp(-5000, 100, 0);
      smp(200, 6000, 0);
      smp(-4854, 31400, 0, 1'b1);
      smp(50, -60, 0);
      smp(-99, 99, 0);
      push_exp(4854, 31400);
      smp(1, 0, 0);
      drain("t4a_drain");

      // Sync on the completing edge suppresses publication.
      smp(20000, 20000, 0);
      smp(20000, 20000, 0);
      smp(20000, 20000, 0);
      smp(1000, 2000, 0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check_val("t4b_no_pub_Vc", int'(Vc_peak), 4854);
      smp(10, 20, 0);
      smp(30, 40, 0);
      push_exp(1000, 2000);
      smp(-50, -60, 0);
      drain("t4b_drain");

      // Drop en mid-window: peaks hold, partial window is discarded.
      smp(100, -10000, 0);
      smp(-3000, 200, 0);
      smp(2500, 9000, 0);
      push_exp(3000, 10000);
      smp(7, -1, 0);
      drain("t5a_pub");
      smp(9000, 9000, 0);
      smp(9000, 9000, 0);
      en = 1'b0;
      @(posedge clk); #1;
      check_val("t5a_busy_off", int'(busy), 0);
      check_val("t5a_hold_Ic", int'(Ic_peak), 10000);
      en = 1'b1;
      @(posedge clk); #1;
      smp(11, 12, 0);
      smp(13, 14, 0);
      smp(-15, -16, 0);
      push_exp(17, 18);
      smp(17, 18, 0);
      drain("t5a_restart");

      // Asynchronous reset mid-window.
      smp(5000, 5000, 0);
      smp(6000, 6000, 0);
      #2;
      rst = 1'b1;
      #1;
      check_val("arst_Vc_peak", int'(Vc_peak), 0);
      check_val("arst_Ic_peak", int'(Ic_peak), 0);
      check_val("arst_pv", int'(peak_valid), 0);
      check_val("arst_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_val("end_queue_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_phase_peak_detector
